// File: rtl/axi_burst_read_engine_pkg.sv
// Encodings and FSM states shared by the AXI burst read and write engines.
package axi_burst_read_engine_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPrep,
      StAr,
      StR,
      StDone
   } state_e;

   localparam logic [1:0] AxiBurstIncr  = 2'b01;
   localparam logic [1:0] AxiRespOkay   = 2'b00;
   localparam logic [1:0] AxiRespSlvErr = 2'b10;

endpackage

// File: rtl/axi_burst_read_engine_if.sv
// AXI4 bus bundle used by the burst engines; the write channels are tied off by readers.
interface axi_burst_read_engine_if #(
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned IdWidth   = 4
) ();

   logic [AddrWidth-1:0] araddr;
   logic [IdWidth-1:0]   arid;
   logic [7:0]           arlen;
   logic [2:0]           arsize;
   logic [1:0]           arburst;
   logic                 arvalid;
   logic                 arready;
   logic [DataWidth-1:0] rdata;
   logic [IdWidth-1:0]   rid;
   logic [1:0]           rresp;
   logic                 rlast;
   logic                 rvalid;
   logic                 rready;
   logic                 awvalid;
   logic                 wvalid;
   logic                 bready;

   modport master (
      output araddr, arid, arlen, arsize, arburst, arvalid, rready, awvalid, wvalid, bready,
      input  arready, rdata, rid, rresp, rlast, rvalid
   );

   modport slave (
      input  araddr, arid, arlen, arsize, arburst, arvalid, rready, awvalid, wvalid, bready,
      output arready, rdata, rid, rresp, rlast, rvalid
   );

endinterface

// File: rtl/axi_burst_read_engine.sv
// Reads data_size words from AXI in INCR bursts of up to AXIMaxBurstLen beats and
// writes them into a local buffer starting at data_ptr.
module axi_burst_read_engine
   import axi_burst_read_engine_pkg::*;
#(
   parameter int unsigned BufferDataWidth = 32,
   parameter int unsigned BufferAddrWidth = 10,
   parameter int unsigned AXIAddrWidth    = 64,
   parameter int unsigned AXIDataWidth    = 32,
   parameter int unsigned AXIIDWidth      = 4,
   parameter int unsigned AXIMaxBurstLen  = 64
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start_valid,
   output logic                       start_ready,
   output logic                       done_valid,
   input  logic                       done_ready,
   input  logic [BufferAddrWidth-1:0] data_ptr,
   input  logic [BufferAddrWidth-1:0] data_size,
   input  logic [AXIAddrWidth-1:0]    axi_offset,
   output logic                       error,
   output logic [BufferAddrWidth-1:0] buffer_addr,
   output logic [BufferDataWidth-1:0] buffer_data,
   output logic                       buffer_ce,
   output logic                       buffer_we,
   axi_burst_read_engine_if.master    axi
);

   localparam int unsigned LenW = 9;
   localparam logic [BufferAddrWidth-1:0] MaxLen     = BufferAddrWidth'(AXIMaxBurstLen);
   localparam logic [BufferAddrWidth-1:0] One        = BufferAddrWidth'(1);
   localparam logic [LenW-1:0]            MaxLenL    = LenW'(AXIMaxBurstLen);
   localparam logic [7:0]                 FullArlen  = 8'(AXIMaxBurstLen - 1);
   localparam logic [AXIAddrWidth-1:0]    BurstBytes = AXIAddrWidth'(AXIMaxBurstLen * AXIDataWidth / 8);
   localparam logic [2:0]                 ArSize     = 3'($clog2(AXIDataWidth / 8));

   state_e                     state_q, state_d;
   logic [BufferAddrWidth-1:0] ptr_q, ptr_d, size_q, size_d;
   logic [BufferAddrWidth-1:0] batches_q, batches_d, batch_q, batch_d, word_q, word_d;
   logic [LenW-1:0]            last_len_q, last_len_d;
   logic [7:0]                 beat_q, beat_d;
   logic [AXIAddrWidth-1:0]    araddr_q, araddr_d;
   logic                       error_q, error_d;

   logic [BufferAddrWidth-1:0] rem;
   logic [7:0]                 arlen;
   logic                       last_batch, beat_fire, burst_end, beat_err;

   assign rem        = size_q % MaxLen;
   assign last_batch = (batch_q == batches_q - One);
   assign arlen      = last_batch ? 8'(last_len_q - LenW'(1)) : FullArlen;
   assign beat_fire  = (state_q == StR) && axi.rvalid;
   assign burst_end  = beat_fire && (beat_q == arlen);
   // Beat counting, not rlast, decides burst end; a bad rlast only flags the error.
   assign beat_err   = (axi.rresp != AxiRespOkay) || (axi.rlast != (beat_q == arlen)) ||
                       (axi.rid != '0);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      size_d     = size_q;
      batches_d  = batches_q;
      batch_d    = batch_q;
      word_d     = word_q;
      last_len_d = last_len_q;
      beat_d     = beat_q;
      araddr_d   = araddr_q;
      error_d    = error_q;
      unique case (state_q)
         StIdle: begin
            if (start_valid) begin
               ptr_d    = data_ptr;
               size_d   = data_size;
               araddr_d = axi_offset;
               error_d  = 1'b0;
               state_d  = StPrep;
            end
         end
         StPrep: begin
            batches_d  = (size_q / MaxLen) + ((rem != '0) ? One : '0);
            last_len_d = (rem == '0) ? MaxLenL : LenW'(rem);
            batch_d    = '0;
            word_d     = '0;
            state_d    = (size_q == '0) ? StDone : StAr;
         end
         StAr: begin
            if (axi.arready) begin
               beat_d  = '0;
               state_d = StR;
            end
         end
         StR: begin
            if (beat_fire) begin
               word_d = word_q + One;
               beat_d = beat_q + 8'd1;
               if (beat_err) error_d = 1'b1;
               if (burst_end) begin
                  araddr_d = araddr_q + BurstBytes;
                  if (last_batch) begin
                     state_d = StDone;
                  end else begin
                     batch_d = batch_q + One;
                     state_d = StAr;
                  end
               end
            end
         end
         StDone: begin
            if (done_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         size_q     <= '0;
         batches_q  <= '0;
         batch_q    <= '0;
         word_q     <= '0;
         last_len_q <= '0;
         beat_q     <= '0;
         araddr_q   <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         size_q     <= size_d;
         batches_q  <= batches_d;
         batch_q    <= batch_d;
         word_q     <= word_d;
         last_len_q <= last_len_d;
         beat_q     <= beat_d;
         araddr_q   <= araddr_d;
         error_q    <= error_d;
      end
   end

   assign start_ready = (state_q == StIdle);
   assign done_valid  = (state_q == StDone);
   assign error       = error_q;
   assign buffer_ce   = beat_fire;
   assign buffer_we   = beat_fire;
   assign buffer_addr = ptr_q + word_q;
   assign buffer_data = axi.rdata;

   assign axi.araddr  = araddr_q;
   assign axi.arid    = {AXIIDWidth{1'b0}};
   assign axi.arlen   = arlen;
   assign axi.arsize  = ArSize;
   assign axi.arburst = AxiBurstIncr;
   assign axi.arvalid = (state_q == StAr);
   assign axi.rready  = (state_q == StR);
   assign axi.awvalid = 1'b0;
   assign axi.wvalid  = 1'b0;
   assign axi.bready  = 1'b0;

endmodule

// File: tb/tb_axi_burst_read_engine.sv
// Directed bench: AXI slave model at negedge, buffer scoreboard, hand-computed expectations.
module tb_axi_burst_read_engine;
   import axi_burst_read_engine_pkg::*;

   localparam logic [31:0] Sentinel = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_valid, start_ready, done_valid, done_ready;
   logic [9:0]  data_ptr, data_size;
   logic [63:0] axi_offset;
   logic        error;
   logic [9:0]  buffer_addr;
   logic [31:0] buffer_data;
   logic        buffer_ce, buffer_we;

   axi_burst_read_engine_if #(.AddrWidth(64), .DataWidth(32), .IdWidth(4)) bus ();

   axi_burst_read_engine dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .data_ptr    (data_ptr),
      .data_size   (data_size),
      .axi_offset  (axi_offset),
      .error       (error),
      .buffer_addr (buffer_addr),
      .buffer_data (buffer_data),
      .buffer_ce   (buffer_ce),
      .buffer_we   (buffer_we),
      .axi         (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] mem [1024];
   logic [63:0] ar_addr_q [$];
   logic [7:0]  ar_len_q [$];
   logic [2:0]  last_arsize;
   logic [1:0]  last_arburst;
   logic [3:0]  last_arid;
   int          ar_delay = 0;
   bit          r_toggle = 1'b0;
   int          err_beat = -1;
   int          early_beat = -1;
   int          nwr = 0, bad_wr = 0, unstable = 0, jbeat = 0, job_no = 0;
   logic [31:0] base = '0;

   // Slave model state
   int          s_ph = 0, s_beat = 0, s_wait = 0;
   bit          s_tog = 1'b1, s_holding = 1'b0;
   logic [7:0]  s_len = '0, s_hlen = '0;
   logic [63:0] s_haddr = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int count_bad(input int ptr, input int size);
      int bad = 0;
      for (int i = 0; i < size; i++) begin
         if (mem[(ptr + i) % 1024] !== base + 32'(i)) bad++;
      end
      return bad;
   endfunction

   initial begin
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rdata   = '0;
      bus.rid     = '0;
      bus.rresp   = 2'b00;
      bus.rlast   = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            bus.arready = 1'b0;
            bus.rvalid  = 1'b0;
            s_ph = 0; s_beat = 0; s_wait = 0; s_tog = 1'b1; s_holding = 1'b0;
         end else begin
            if (s_ph == 0) begin
               bus.rvalid  = 1'b0;
               bus.arready = bus.arvalid && (s_wait >= ar_delay);
               if (bus.arvalid) s_wait++;
            end else begin
               bus.arready = 1'b0;
               bus.rvalid  = r_toggle ? s_tog : 1'b1;
               s_tog       = ~s_tog;
               bus.rdata   = base + 32'(jbeat);
               bus.rresp   = (jbeat == err_beat) ? AxiRespSlvErr : AxiRespOkay;
               bus.rlast   = (s_beat == int'(s_len)) || (jbeat == early_beat);
            end
            #1;
            if (buffer_we && !(bus.rvalid && bus.rready)) bad_wr++;
            if (bus.rvalid && bus.rready && !(buffer_we && buffer_ce)) bad_wr++;
            if (buffer_we) begin
               mem[buffer_addr] = buffer_data;
               nwr++;
            end
            if (bus.arvalid && !bus.arready) begin
               if (s_holding && (bus.araddr != s_haddr || bus.arlen != s_hlen)) unstable++;
               s_holding = 1'b1;
               s_haddr   = bus.araddr;
               s_hlen    = bus.arlen;
            end
            if (bus.arvalid && bus.arready) begin
               ar_addr_q.push_back(bus.araddr);
               ar_len_q.push_back(bus.arlen);
               last_arsize  = bus.arsize;
               last_arburst = bus.arburst;
               last_arid    = bus.arid;
               s_len = bus.arlen; s_beat = 0; s_ph = 1; s_wait = 0; s_holding = 1'b0;
               s_tog = 1'b1;
            end else if (s_ph == 1 && bus.rvalid && bus.rready) begin
               jbeat++;
               if (s_beat == int'(s_len)) s_ph = 0;
               else s_beat++;
            end
         end
      end
   end

   task automatic run_job(input logic [9:0] ptr, input logic [9:0] size, input logic [63:0] off,
                          output int lat, output logic err);
      job_no++;
      base = 32'hA000_0000 + 32'(job_no << 12);
      for (int i = 0; i < 1024; i++) mem[i] = Sentinel;
      ar_addr_q.delete();
      ar_len_q.delete();
      nwr = 0; bad_wr = 0; unstable = 0; jbeat = 0;
      @(negedge clk);
      data_ptr = ptr; data_size = size; axi_offset = off; start_valid = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         start_valid = 1'b0;
         lat++;
      end while (!done_valid && lat < 2000);
      if (!done_valid) check_val("done_timeout", 64'd0, 64'd1);
      err = error;
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      check_val("done_cleared", done_valid, 0);
      check_val("idle_start_ready", start_ready, 1);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      int   lat, wait_n;
      logic err;
      reset_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
      data_ptr = '0; data_size = '0; axi_offset = '0;
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_start_ready", start_ready, 1);
      check_val("rst_done_valid", done_valid, 0);
      check_val("rst_arvalid", bus.arvalid, 0);
      check_val("rst_rready", bus.rready, 0);
      check_val("rst_buffer_we_ce", {buffer_we, buffer_ce}, 0);
      check_val("rst_error", error, 0);
      check_val("tieoff_aw_w_b", {bus.awvalid, bus.wvalid, bus.bready}, 0);
      @(negedge clk);
      #3 reset_n = 1'b1;

      // Single 10-beat burst
      run_job(10'd5, 10'd10, 64'h1000, lat, err);
      check_val("a_latency", lat, 13);
      check_val("a_ar_count", ar_addr_q.size(), 1);
      check_val("a_araddr", ar_addr_q[0], 64'h1000);
      check_val("a_arlen", ar_len_q[0], 9);
      check_val("a_arsize", last_arsize, 2);
      check_val("a_arburst", last_arburst, 2'b01);
      check_val("a_arid", last_arid, 0);
      for (int i = 0; i < 10; i++) check_val($sformatf("a_word%0d", 5 + i), mem[5 + i], base + 32'(i));
      check_val("a_below_untouched", mem[4], Sentinel);
      check_val("a_above_untouched", mem[15], Sentinel);
      check_val("a_writes", nwr, 10);
      check_val("a_error", err, 0);

      // Three bursts: 64 + 64 + 2
      run_job(10'd0, 10'd130, 64'h0, lat, err);
      check_val("b_latency", lat, 135);
      check_val("b_ar_count", ar_addr_q.size(), 3);
      check_val("b_arlen0", ar_len_q[0], 63);
      check_val("b_arlen1", ar_len_q[1], 63);
      check_val("b_arlen2", ar_len_q[2], 1);
      check_val("b_araddr0", ar_addr_q[0], 64'h0);
      check_val("b_araddr1", ar_addr_q[1], 64'h100);
      check_val("b_araddr2", ar_addr_q[2], 64'h200);
      check_val("b_writes", nwr, 130);
      check_val("b_data_bad", count_bad(0, 130), 0);
      check_val("b_error", err, 0);

      // Slow arready and gappy rvalid
      ar_delay = 5; r_toggle = 1'b1;
      run_job(10'd200, 10'd64, 64'h4000, lat, err);
      ar_delay = 0; r_toggle = 1'b0;
      check_val("c_ar_count", ar_addr_q.size(), 1);
      check_val("c_arlen", ar_len_q[0], 63);
      check_val("c_ar_unstable", unstable, 0);
      check_val("c_writes", nwr, 64);
      check_val("c_bad_writes", bad_wr, 0);
      check_val("c_data_bad", count_bad(200, 64), 0);

      // Empty job
      run_job(10'd3, 10'd0, 64'h8000, lat, err);
      check_val("d_latency", lat, 2);
      check_val("d_ar_count", ar_addr_q.size(), 0);
      check_val("d_writes", nwr, 0);
      check_val("d_error", err, 0);

      // SLVERR on beat 3
      err_beat = 3;
      run_job(10'd0, 10'd10, 64'h5000, lat, err);
      err_beat = -1;
      check_val("e_error", err, 1);
      check_val("e_writes", nwr, 10);
      check_val("e_data_bad", count_bad(0, 10), 0);

      // Early rlast on beat 7
      early_beat = 7;
      run_job(10'd0, 10'd10, 64'h5000, lat, err);
      early_beat = -1;
      check_val("f_error", err, 1);
      check_val("f_writes", nwr, 10);
      check_val("f_latency", lat, 13);

      // Clean job after an error, buffer address wraps
      run_job(10'd1020, 10'd10, 64'h6000, lat, err);
      check_val("g_error_cleared", err, 0);
      check_val("g_data_bad", count_bad(1020, 10), 0);
      check_val("g_after_wrap_untouched", mem[6], Sentinel);
      check_val("g_before_ptr_untouched", mem[1019], Sentinel);

      // Reset in the middle of R
      for (int i = 0; i < 1024; i++) mem[i] = Sentinel;
      nwr = 0; jbeat = 0;
      @(negedge clk);
      data_ptr = 10'd0; data_size = 10'd64; axi_offset = 64'h7000; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      wait_n = 0;
      while (nwr < 20 && wait_n < 500) begin
         @(negedge clk);
         wait_n++;
      end
      check_val("h_reached_mid_r", nwr >= 20, 1);
      #2 reset_n = 1'b0;
      #1;
      check_val("h_rst_rready", bus.rready, 0);
      check_val("h_rst_arvalid", bus.arvalid, 0);
      check_val("h_rst_buffer_we_ce", {buffer_we, buffer_ce}, 0);
      check_val("h_rst_done_valid", done_valid, 0);
      check_val("h_rst_start_ready", start_ready, 1);
      repeat (2) @(negedge clk);
      #3 reset_n = 1'b1;
      #1;
      check_val("h_release_start_ready", start_ready, 1);
      run_job(10'd100, 10'd10, 64'h3000, lat, err);
      check_val("h_latency", lat, 13);
      check_val("h_ar_count", ar_addr_q.size(), 1);
      check_val("h_araddr", ar_addr_q[0], 64'h3000);
      check_val("h_data_bad", count_bad(100, 10), 0);
      check_val("h_writes", nwr, 10);
      check_val("h_error", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
